// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter: word-length and FSM
// encodings, word-length decode and stop-bit lengths counted in half-bit ticks.
package uart_pkg;

  typedef enum logic [1:0] {
    WLS_5 = 2'b00,
    WLS_6 = 2'b01,
    WLS_7 = 2'b10,
    WLS_8 = 2'b11
  } wls_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  localparam logic [2:0] STOP_TICKS_1   = 3'd2;
  localparam logic [2:0] STOP_TICKS_1P5 = 3'd3;
  localparam logic [2:0] STOP_TICKS_2   = 3'd4;

  // Index of the last data bit (N-1) for a word-length code.
  function automatic logic [2:0] wls_last_bit(input wls_e w);
    logic [2:0] last;
    case (w)
      WLS_5:   last = 3'd4;
      WLS_6:   last = 3'd5;
      WLS_7:   last = 3'd6;
      default: last = 3'd7;
    endcase
    return last;
  endfunction

endpackage

// File: rtl/uart_tx_top_baud_gen.sv
// Free-running baud tick generator: one-cycle registered pulse every DIVISOR
// sys_clk cycles, asserted while the counter sits at DIVISOR-1.
module baud_gen #(
  parameter int DIVISOR = 6
) (
  input  logic sys_clk,
  input  logic reset,
  output logic baud_tick
);

  localparam int CW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // The tick is registered from the next count so it lines up with cnt_q == LAST.
  always_comb begin
    cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    tick_d = (cnt_d == LAST);
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign baud_tick = tick_q;

endmodule

// File: rtl/uart_tx_top.sv
// UART transmitter: pops the THR and serializes start/data/parity/stop on txd_o.
// Define UART_TX_HALF_STOP_EN to get 1.5 stop bits for 5-bit words with stop_bit=1.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int DIVISOR = 6
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic [7:0] tx_data_i,
  input  logic       parity_en,
  input  logic       sticky_parity,
  input  logic       eps,
  input  logic       stop_bit,
  input  logic [1:0] wls,
  input  logic       Txhr_empty,
  output logic       baud_tick,
  output logic       txd_o,
  output logic       tx_done,
  output logic       Txsr_empty,
  output logic       Txhr_rd_en
);

`ifdef UART_TX_HALF_STOP_EN
  localparam bit HalfStopEn = 1'b1;
`else
  localparam bit HalfStopEn = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [1:0] sub_q, sub_d;
  logic [2:0] bit_q, bit_d;
  logic [2:0] last_q, last_d;
  logic [2:0] stop_ticks_q, stop_ticks_d;
  logic [7:0] shreg_q, shreg_d;
  logic       par_en_q, par_en_d;
  logic       par_q, par_d;
  logic       txd_q, txd_d;
  logic       done_q, done_d;
  logic       rd_q, rd_d;
  logic       sr_empty_q, sr_empty_d;
  logic       load, frame_end;
  logic       tick;

  function automatic logic calc_parity(input logic [7:0] d, input logic [2:0] last,
                                       input logic sticky, input logic even);
    logic [7:0] mask;
    logic       x;
    mask = 8'hFF >> (4'd7 - {1'b0, last});
    x    = ^(d & mask);
    return sticky ? ~even : (even ? x : ~x);
  endfunction

  function automatic logic [2:0] calc_stop_ticks(input logic sb, input wls_e w);
    logic [2:0] t;
    if (!sb)                          t = STOP_TICKS_1;
    else if (HalfStopEn && w == WLS_5) t = STOP_TICKS_1P5;
    else                              t = STOP_TICKS_2;
    return t;
  endfunction

  baud_gen #(.DIVISOR(DIVISOR)) u_baud_gen (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .baud_tick(tick)
  );

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Every state is measured in half-bit ticks via sub_q.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    frame_end = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: if (!Txhr_empty) begin
          state_d = START;
          load    = 1'b1;
        end
        START:  if (sub_q == 2'd1) state_d = DATA;
        DATA:   if (sub_q == 2'd1 && bit_q == last_q) state_d = par_en_q ? PARITY : STOP;
        PARITY: if (sub_q == 2'd1) state_d = STOP;
        STOP: if ({1'b0, sub_q} == stop_ticks_q - 3'd1) begin
          frame_end = 1'b1;
          if (!Txhr_empty) begin
            state_d = START;
            load    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    sub_d        = sub_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    txd_d        = txd_q;
    done_d       = 1'b0;
    rd_d         = 1'b0;
    sr_empty_d   = sr_empty_q;
    last_d       = last_q;
    stop_ticks_d = stop_ticks_q;
    par_en_d     = par_en_q;
    par_d        = par_q;
    if (tick) begin
      sub_d = (state_q == IDLE || state_d != state_q || (state_q == DATA && sub_q == 2'd1))
              ? 2'd0 : sub_q + 2'd1;
      case (state_q)
        START: if (state_d == DATA) txd_d = shreg_q[0];
        DATA: if (sub_q == 2'd1) begin
          if (state_d == DATA) begin
            shreg_d = shreg_q >> 1;
            bit_d   = bit_q + 3'd1;
            txd_d   = shreg_q[1];
          end else begin
            txd_d = (state_d == PARITY) ? par_q : 1'b1;
          end
        end
        PARITY: if (state_d == STOP) txd_d = 1'b1;
        STOP: if (frame_end) begin
          done_d     = 1'b1;
          sr_empty_d = 1'b1;
          txd_d      = 1'b1;
        end
        default: ;
      endcase
      // A back-to-back load on the last stop tick overrides the idle values above.
      if (load) begin
        shreg_d      = tx_data_i;
        bit_d        = 3'd0;
        txd_d        = 1'b0;
        rd_d         = 1'b1;
        sr_empty_d   = 1'b0;
        last_d       = wls_last_bit(wls_e'(wls));
        stop_ticks_d = calc_stop_ticks(stop_bit, wls_e'(wls));
        par_en_d     = parity_en;
        par_d        = calc_parity(tx_data_i, wls_last_bit(wls_e'(wls)), sticky_parity, eps);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      sub_q      <= 2'd0;
      bit_q      <= 3'd0;
      txd_q      <= 1'b1;
      done_q     <= 1'b0;
      rd_q       <= 1'b0;
      sr_empty_q <= 1'b1;
    end else begin
      sub_q      <= sub_d;
      bit_q      <= bit_d;
      txd_q      <= txd_d;
      done_q     <= done_d;
      rd_q       <= rd_d;
      sr_empty_q <= sr_empty_d;
    end
  end

  // Frame payload only matters after a load, so it carries no reset.
  always_ff @(posedge sys_clk) begin
    shreg_q      <= shreg_d;
    last_q       <= last_d;
    stop_ticks_q <= stop_ticks_d;
    par_en_q     <= par_en_d;
    par_q        <= par_d;
  end

  assign baud_tick  = tick;
  assign txd_o      = txd_q;
  assign tx_done    = done_q;
  assign Txsr_empty = sr_empty_q;
  assign Txhr_rd_en = rd_q;

endmodule

// File: tb/tb_uart_tx_top.sv
// Directed bench for uart_tx_top at DIVISOR=6 (one bit = 12 sys_clk cycles).
module tb_uart_tx_top;

  logic       sys_clk;
  logic       reset;
  logic [7:0] tx_data_i;
  logic       parity_en;
  logic       sticky_parity;
  logic       eps;
  logic       stop_bit;
  logic [1:0] wls;
  logic       Txhr_empty;
  logic       baud_tick;
  logic       txd_o;
  logic       tx_done;
  logic       Txsr_empty;
  logic       Txhr_rd_en;

  int checks = 0;
  int fails  = 0;

  uart_tx_top #(.DIVISOR(6)) dut (
    .sys_clk      (sys_clk),
    .reset        (reset),
    .tx_data_i    (tx_data_i),
    .parity_en    (parity_en),
    .sticky_parity(sticky_parity),
    .eps          (eps),
    .stop_bit     (stop_bit),
    .wls          (wls),
    .Txhr_empty   (Txhr_empty),
    .baud_tick    (baud_tick),
    .txd_o        (txd_o),
    .tx_done      (tx_done),
    .Txsr_empty   (Txsr_empty),
    .Txhr_rd_en   (Txhr_rd_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Bit k of exp_bits is the line value expected in the middle of bit k of the frame.
  task automatic run_frame(input string tag, input logic [7:0] d, input logic [1:0] w,
                           input logic pe, input logic st, input logic ep, input logic sb,
                           input logic [11:0] exp_bits, input int nb, input int exp_len);
    int n;
    int rds;
    int dones;
    logic [11:0] got;
    @(negedge sys_clk);
    tx_data_i = d; wls = w; parity_en = pe; sticky_parity = st; eps = ep; stop_bit = sb;
    Txhr_empty = 1'b0;
    n = 0;
    while (Txhr_rd_en !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    Txhr_empty = 1'b1;
    chk1({tag, "_rd_seen"}, Txhr_rd_en, 1'b1);
    chk1({tag, "_start_low"}, txd_o, 1'b0);
    chk1({tag, "_sr_busy"}, Txsr_empty, 1'b0);
    rds = 1; dones = 0; got = '0; n = 0;
    while (dones == 0 && n < 300) begin
      @(negedge sys_clk);
      n++;
      if (n % 12 == 6 && n / 12 < nb) got[n/12] = txd_o;
      if (Txhr_rd_en === 1'b1) rds++;
      if (tx_done === 1'b1) dones++;
    end
    chkn({tag, "_bits"}, 32'(got), 32'(exp_bits));
    chkn({tag, "_len"}, n, exp_len);
    chkn({tag, "_rd_count"}, rds, 1);
    chkn({tag, "_done_count"}, dones, 1);
    chk1({tag, "_sr_idle"}, Txsr_empty, 1'b1);
    @(negedge sys_clk);
    chk1({tag, "_done_pulse"}, tx_done, 1'b0);
    chk1({tag, "_line_idle"}, txd_o, 1'b1);
  endtask

  initial begin
    int n;
    int rd2_at;
    int done1_at;
    int done2_at;
    int dones;
    int lows;
    logic txd_at_120;
    logic [11:0] got1;
    logic [11:0] got2;

    reset = 1'b0; Txhr_empty = 1'b1; tx_data_i = 8'h00;
    parity_en = 1'b0; sticky_parity = 1'b0; eps = 1'b0; stop_bit = 1'b0; wls = 2'b00;
    repeat (3) @(negedge sys_clk);
    chk1("rst_txd", txd_o, 1'b1);
    chk1("rst_sr_empty", Txsr_empty, 1'b1);
    chk1("rst_done", tx_done, 1'b0);
    chk1("rst_rd_en", Txhr_rd_en, 1'b0);
    chk1("rst_tick", baud_tick, 1'b0);

    reset = 1'b1;
    n = 0;
    while (baud_tick !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chkn("tick_first", n, 5);
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
      if (n == 1) chk1("tick_width", baud_tick, 1'b0);
    end while (baud_tick !== 1'b1 && n < 20);
    chkn("tick_period", n, 6);

    run_frame("a5_8n1",     8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, {2'b0, 1'b1, 8'hA5, 1'b0}, 10, 120);
    run_frame("5a_7e1",     8'h5A, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, {2'b0, 1'b1, 1'b0, 7'h5A, 1'b0}, 10, 120);
    run_frame("3c_6o1",     8'h3C, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, {3'b0, 1'b1, 1'b1, 6'h3C, 1'b0}, 9, 108);
    run_frame("ff_8stk",    8'hFF, 2'b11, 1'b1, 1'b1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 132);
    run_frame("00_5stk",    8'h00, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, {4'b0, 1'b1, 1'b0, 5'h00, 1'b0}, 8, 96);
    run_frame("c3_8n2",     8'hC3, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, {2'b0, 1'b1, 8'hC3, 1'b0}, 10, 132);
`ifdef UART_TX_HALF_STOP_EN
    run_frame("1f_5n1p5",   8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, {5'b0, 1'b1, 5'h1F, 1'b0}, 7, 90);
`else
    run_frame("1f_5n2",     8'h1F, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, {5'b0, 1'b1, 5'h1F, 1'b0}, 7, 96);
`endif

    // Back-to-back: THR stays full, data changes mid-frame must not disturb frame one.
    @(negedge sys_clk);
    tx_data_i = 8'h55; wls = 2'b11; parity_en = 1'b0; sticky_parity = 1'b0; eps = 1'b0; stop_bit = 1'b0;
    Txhr_empty = 1'b0;
    n = 0;
    while (Txhr_rd_en !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    chk1("b2b_rd1", Txhr_rd_en, 1'b1);
    tx_data_i = 8'h0F;
    rd2_at = 0; done1_at = 0; done2_at = 0; dones = 0; txd_at_120 = 1'b1;
    got1 = '0; got2 = '0;
    for (int i = 1; i <= 245; i++) begin
      @(negedge sys_clk);
      if (i % 12 == 6) begin
        if (i < 120) got1[i/12] = txd_o;
        else if (i < 240) got2[(i-120)/12] = txd_o;
      end
      if (i == 120) txd_at_120 = txd_o;
      if (Txhr_rd_en === 1'b1 && rd2_at == 0) begin
        rd2_at = i;
        Txhr_empty = 1'b1;
      end
      if (tx_done === 1'b1) begin
        dones++;
        if (done1_at == 0) done1_at = i;
        else if (done2_at == 0) done2_at = i;
      end
    end
    chkn("b2b_rd2_at", rd2_at, 120);
    chkn("b2b_done1_at", done1_at, 120);
    chkn("b2b_done2_at", done2_at, 240);
    chkn("b2b_done_count", dones, 2);
    chk1("b2b_no_gap", txd_at_120, 1'b0);
    chkn("b2b_bits1", 32'(got1), 32'({1'b1, 8'h55, 1'b0}));
    chkn("b2b_bits2", 32'(got2), 32'({1'b1, 8'h0F, 1'b0}));

    // Reset in the middle of the data bits.
    @(negedge sys_clk);
    tx_data_i = 8'hA5; wls = 2'b11; stop_bit = 1'b0;
    Txhr_empty = 1'b0;
    n = 0;
    while (Txhr_rd_en !== 1'b1 && n < 20) begin
      @(negedge sys_clk);
      n++;
    end
    Txhr_empty = 1'b1;
    chk1("rstmid_rd", Txhr_rd_en, 1'b1);
    repeat (30) @(negedge sys_clk);
    chk1("rstmid_data_bit1", txd_o, 1'b0);
    chk1("rstmid_busy", Txsr_empty, 1'b0);
    reset = 1'b0;
    #1;
    chk1("rstmid_txd", txd_o, 1'b1);
    chk1("rstmid_sr_empty", Txsr_empty, 1'b1);
    chk1("rstmid_done", tx_done, 1'b0);
    @(negedge sys_clk);
    reset = 1'b1;
    dones = 0; lows = 0;
    repeat (150) begin
      @(negedge sys_clk);
      if (tx_done === 1'b1) dones++;
      if (txd_o !== 1'b1) lows++;
    end
    chkn("rstmid_no_done", dones, 0);
    chkn("rstmid_line_high", lows, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
